// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI4-Lite initiator bridging a CPU valid/ready request port to AXI-Lite.
// Optional hung-slave timeout recovery enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_master_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [STRB_WIDTH-1:0] req_wstrb,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("axil_master_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RESP
   } state_t;

   state_t                state, state_n;
   logic                  req_ready_n, awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
   logic                  rsp_valid_n, rsp_err_n;
   logic [DATA_WIDTH-1:0] rsp_rdata_n;
   logic                  aw_done, aw_done_n, w_done, w_done_n;
   logic [ADDR_WIDTH-1:0] addr_q, addr_n;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_n;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
`endif

   assign m_axil_awaddr = addr_q;
   assign m_axil_araddr = addr_q;
   assign m_axil_wdata  = wdata_q;
   assign m_axil_wstrb  = wstrb_q;
   assign m_axil_awprot = 3'b000;
   assign m_axil_arprot = 3'b000;

   // State and registered outputs
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state          <= S_IDLE;
         req_ready      <= 1'b0;
         m_axil_awvalid <= 1'b0;
         m_axil_wvalid  <= 1'b0;
         m_axil_bready  <= 1'b0;
         m_axil_arvalid <= 1'b0;
         m_axil_rready  <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_err        <= 1'b0;
         rsp_rdata      <= '0;
         aw_done        <= 1'b0;
         w_done         <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
`ifdef AXIL_MASTER_TIMEOUT_EN
         tmo_cnt        <= '0;
`endif
      end else begin
         state          <= state_n;
         req_ready      <= req_ready_n;
         m_axil_awvalid <= awvalid_n;
         m_axil_wvalid  <= wvalid_n;
         m_axil_bready  <= bready_n;
         m_axil_arvalid <= arvalid_n;
         m_axil_rready  <= rready_n;
         rsp_valid      <= rsp_valid_n;
         rsp_err        <= rsp_err_n;
         rsp_rdata      <= rsp_rdata_n;
         aw_done        <= aw_done_n;
         w_done         <= w_done_n;
         addr_q         <= addr_n;
         wdata_q        <= wdata_n;
         wstrb_q        <= wstrb_n;
`ifdef AXIL_MASTER_TIMEOUT_EN
         tmo_cnt        <= tmo_cnt_n;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      req_ready_n = 1'b0;
      awvalid_n   = m_axil_awvalid;
      wvalid_n    = m_axil_wvalid;
      bready_n    = m_axil_bready;
      arvalid_n   = m_axil_arvalid;
      rready_n    = m_axil_rready;
      rsp_valid_n = 1'b0;
      rsp_err_n   = rsp_err;
      rsp_rdata_n = rsp_rdata;
      aw_done_n   = aw_done;
      w_done_n    = w_done;
      addr_n      = addr_q;
      wdata_n     = wdata_q;
      wstrb_n     = wstrb_q;

      case (state)
         S_IDLE: begin
            req_ready_n = 1'b1;
            if (req_valid && req_ready) begin
               req_ready_n = 1'b0;
               addr_n      = req_addr;
               wdata_n     = req_wdata;
               wstrb_n     = req_wstrb;
               aw_done_n   = 1'b0;
               w_done_n    = 1'b0;
               state_n     = req_we ? S_WR_REQ : S_RD_ADDR;
            end
         end
         S_WR_REQ: begin
            // Address and data channels retire independently
            aw_done_n = aw_done || (m_axil_awvalid && m_axil_awready);
            w_done_n  = w_done  || (m_axil_wvalid  && m_axil_wready);
            awvalid_n = !aw_done_n;
            wvalid_n  = !w_done_n;
            if (aw_done_n && w_done_n) begin
               bready_n = 1'b1;
               state_n  = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (m_axil_bvalid && m_axil_bready) begin
               bready_n    = 1'b0;
               rsp_valid_n = 1'b1;
               rsp_err_n   = (m_axil_bresp != 2'b00);
               rsp_rdata_n = '0;
               state_n     = S_RESP;
            end
         end
         S_RD_ADDR: begin
            if (m_axil_arvalid && m_axil_arready) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = S_RD_DATA;
            end else begin
               arvalid_n = 1'b1;
            end
         end
         S_RD_DATA: begin
            if (m_axil_rvalid && m_axil_rready) begin
               rready_n    = 1'b0;
               rsp_valid_n = 1'b1;
               rsp_err_n   = (m_axil_rresp != 2'b00);
               rsp_rdata_n = m_axil_rdata;
               state_n     = S_RESP;
            end
         end
         S_RESP: begin
            req_ready_n = 1'b1;
            state_n     = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
      // Hung-slave recovery: abandon the AXI transaction and report an error
      tmo_cnt_n = tmo_cnt;
      if (state == S_IDLE) begin
         tmo_cnt_n = '0;
      end else if (state != S_RESP) begin
         if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            awvalid_n   = 1'b0;
            wvalid_n    = 1'b0;
            bready_n    = 1'b0;
            arvalid_n   = 1'b0;
            rready_n    = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
            state_n     = S_RESP;
         end else begin
            tmo_cnt_n = tmo_cnt + TMO_W'(1);
         end
      end
`endif
   end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Scoreboard bench for axil_master_bridge with a small AXI-Lite memory slave model.
module tb_axil_master_bridge;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   axil_master_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
      .m_axil_awready(awready),
      .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
      .m_axil_wready(wready),
      .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
      .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
      .m_axil_arready(arready),
      .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
      .m_axil_rready(rready)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        chk_rdata;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   rsp_count = 0;
   int   last_rsp_edge = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave knobs and state
   int          aw_delay = 0, w_delay = 0, b_delay = 0;
   bit          ar_never = 0;
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   logic [31:0] aw_l, w_l, ar_l;
   logic [3:0]  ws_l;
   logic [31:0] mem [0:63];

   // AXI-Lite slave: drives on the falling edge, memory indexed by addr[7:2]; 0x40..0x4F errors
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rresp = 0; rdata = 0;
      aw_l = 0; w_l = 0; ar_l = 0; ws_l = 0;
      forever begin
         @(negedge aclk);
         awready = awvalid && (aw_cnt >= aw_delay);
         if (awvalid && awready) begin aw_l = awaddr; aw_cnt = 0; end
         else if (awvalid) aw_cnt++;
         else aw_cnt = 0;
         wready = wvalid && (w_cnt >= w_delay);
         if (wvalid && wready) begin w_l = wdata; ws_l = wstrb; w_cnt = 0; end
         else if (wvalid) w_cnt++;
         else w_cnt = 0;
         bvalid = bready && (b_cnt >= b_delay);
         if (bvalid) begin
            for (int b = 0; b < 4; b++)
               if (ws_l[b]) mem[aw_l[7:2]][b*8 +: 8] = w_l[b*8 +: 8];
            bresp = (aw_l[7:4] == 4'h4) ? 2'b10 : 2'b00;
            b_cnt = 0;
         end else if (bready) b_cnt++;
         else b_cnt = 0;
         arready = arvalid && !ar_never;
         if (arvalid && arready) ar_l = araddr;
         rvalid = rready;
         rdata  = mem[ar_l[7:2]];
         rresp  = (ar_l[7:4] == 4'h4) ? 2'b10 : 2'b00;
      end
   end

   // Response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge aclk);
         if (aresetn === 1'b1 && rsp_valid === 1'b1) begin
            rsp_count++;
            last_rsp_edge = cyc + 1;
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_err", 64'(rsp_err), 64'(e.err));
               if (e.chk_rdata) check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input bit push, input exp_t e, output int acc);
      acc = -1;
      if (push) exp_q.push_back(e);
      @(negedge aclk);
      req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (req_ready) begin
            acc = cyc + 1;
            @(posedge aclk);
            #1;
            break;
         end
         @(negedge aclk);
      end
      req_valid = 1'b0;
      if (acc < 0) check("req_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic observe(input int acc, output int lat, output int aw_hi, output int w_hi,
                          output int ar_hi, output int aw_first, output int w_first,
                          output logic ar_at_rsp);
      int start;
      start = rsp_count;
      lat = -1; aw_hi = 0; w_hi = 0; ar_hi = 0; aw_first = -1; w_first = -1; ar_at_rsp = 1'bx;
      for (int i = 0; i < 60; i++) begin
         @(negedge aclk);
         #1;
         if (awvalid) begin if (aw_hi == 0) aw_first = cyc; aw_hi++; end
         if (wvalid)  begin if (w_hi == 0)  w_first  = cyc; w_hi++;  end
         if (arvalid) ar_hi++;
         if (rsp_count != start) begin
            lat = last_rsp_edge - acc;
            ar_at_rsp = arvalid;
            break;
         end
      end
   endtask

   initial begin
      int   acc, acc2, lat, aw_hi, w_hi, ar_hi, aw_first, w_first, cnt0;
      logic ar_at_rsp;
      exp_t e;
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk); #1;
      check("reset_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, req_ready, rsp_valid, rsp_err}), 64'd0);
      check("reset_rdata", 64'(rsp_rdata), 64'd0);
      aresetn = 1'b1;

      // 1: write, slave immediate
      e = '{32'h0, 1'b0, 1'b0};
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, e, acc);
      observe(acc, lat, aw_hi, w_hi, ar_hi, aw_first, w_first, ar_at_rsp);
      check("t1_latency", 64'(lat), 64'd4);
      check("t1_aw_w_same_cycle", 64'(aw_first), 64'(w_first));
      check("t1_aw_cycles", 64'(aw_hi), 64'd1);
      check("t1_w_cycles", 64'(w_hi), 64'd1);

      // 2: read back
      e = '{32'hDEADBEEF, 1'b0, 1'b1};
      issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, e, acc);
      observe(acc, lat, aw_hi, w_hi, ar_hi, aw_first, w_first, ar_at_rsp);
      check("t2_latency", 64'(lat), 64'd4);
      check("t2_ar_cycles", 64'(ar_hi), 64'd1);

      // 3: awready delayed 3 cycles, partial strobe
      aw_delay = 3;
      e = '{32'h0, 1'b0, 1'b0};
      issue(1'b1, 32'h24, 32'h12345678, 4'h3, 1'b1, e, acc);
      cnt0 = rsp_count;
      observe(acc, lat, aw_hi, w_hi, ar_hi, aw_first, w_first, ar_at_rsp);
      check("t3_latency", 64'(lat), 64'd7);
      check("t3_aw_cycles", 64'(aw_hi), 64'd4);
      check("t3_w_cycles", 64'(w_hi), 64'd1);
      check("t3_aw_w_same_cycle", 64'(aw_first), 64'(w_first));
      repeat (5) @(negedge aclk);
      check("t3_single_rsp", 64'(rsp_count - cnt0), 64'd1);
      aw_delay = 0;

      // 4: read error, then back-to-back request
      e = '{32'h0, 1'b1, 1'b0};
      issue(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, e, acc);
      e = '{32'hDEADBEEF, 1'b0, 1'b1};
      issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, e, acc2);
      check("t4_accept_after_rsp", 64'(acc2 - last_rsp_edge), 64'd1);
      observe(acc2, lat, aw_hi, w_hi, ar_hi, aw_first, w_first, ar_at_rsp);
      check("t4b_latency", 64'(lat), 64'd4);

      // 5: reset while waiting for the write response
      b_delay = 1000;
      e = '{32'h0, 1'b0, 1'b0};
      issue(1'b1, 32'h30, 32'hAAAA5555, 4'hF, 1'b0, e, acc);
      for (int i = 0; i < 20 && bready !== 1'b1; i++) begin
         @(negedge aclk); #1;
      end
      check("t5_reached_wr_resp", 64'(bready), 64'd1);
      cnt0 = rsp_count;
      aresetn = 1'b0;
      @(negedge aclk); #1;
      check("t5_reset_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, req_ready, rsp_valid}), 64'd0);
      check("t5_reset_rdata", 64'(rsp_rdata), 64'd0);
      aresetn = 1'b1;
      b_delay = 0;
      repeat (4) @(negedge aclk);
      check("t5_no_rsp", 64'(rsp_count - cnt0), 64'd0);
      e = '{32'h00005678, 1'b0, 1'b1};
      issue(1'b0, 32'h24, 32'h0, 4'h0, 1'b1, e, acc);
      observe(acc, lat, aw_hi, w_hi, ar_hi, aw_first, w_first, ar_at_rsp);
      check("t5_read_latency", 64'(lat), 64'd4);

`ifdef AXIL_MASTER_TIMEOUT_EN
      // 6: arready never arrives
      ar_never = 1;
      e = '{32'h0, 1'b1, 1'b1};
      issue(1'b0, 32'h80, 32'h0, 4'h0, 1'b1, e, acc);
      observe(acc, lat, aw_hi, w_hi, ar_hi, aw_first, w_first, ar_at_rsp);
      check("t6_timeout_latency", 64'(lat), 64'd9);
      check("t6_arvalid_dropped", 64'(ar_at_rsp), 64'd0);
      ar_never = 0;
`endif

      repeat (3) @(negedge aclk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
